// File: rtl/cga_vram_arbiter.sv
// rtl/cga_vram_arbiter.sv - CGA VRAM arbiter between ISA CPU accesses and video fetch
//
// Purpose: shares a single-port VRAM between the display sequencer and the ISA
// bus. CPU accesses are confined to a fixed slot of the clkdiv sequencer
// (SLOT_START..SLOT_END); all other cycles belong to video fetch.
//
// Ports:
//   clk, reset            - sole clock, asynchronous active-high reset
//   clkdiv[4:0]           - sequencer phase
//   bus_a/bus_d           - ISA address / write data
//   bus_memr_l/bus_memw_l - ISA memory strobes (asynchronous, active-low)
//   bus_aen               - ISA DMA address enable (blocks decode)
//   bus_out/bus_dir       - CPU read data / read-drive enable
//   bus_rdy               - ISA ready (low inserts wait states)
//   vid_a/vid_req/vid_d   - video fetch address, request, captured data
//   snow                  - one-cycle flag when video data was corrupted by a CPU access
//   ram_a/ram_we_l/ram_wd/ram_d - VRAM port
module cga_vram_arbiter #(
  parameter logic [19:0] FB_BASE      = 20'hB8000,
  parameter int          WIN_LOG2     = 15,
  parameter int          ADDR_WIDTH   = 14,
  parameter int          SLOT_START   = 17,
  parameter int          SLOT_END     = 20,
  parameter int          USE_BUS_WAIT = 1,
  parameter int          SNOW         = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            clkdiv,
  input  logic [19:0]           bus_a,
  input  logic [7:0]            bus_d,
  input  logic                  bus_memr_l,
  input  logic                  bus_memw_l,
  input  logic                  bus_aen,
  output logic [7:0]            bus_out,
  output logic                  bus_dir,
  output logic                  bus_rdy,
  input  logic [ADDR_WIDTH-1:0] vid_a,
  input  logic                  vid_req,
  output logic [7:0]            vid_d,
  output logic                  snow,
  output logic [18:0]           ram_a,
  output logic                  ram_we_l,
  output logic [7:0]            ram_wd,
  input  logic [7:0]            ram_d
);

  localparam logic [4:0] SS     = 5'(SLOT_START);
  localparam logic [4:0] SE     = 5'(SLOT_END);
  // ACCESS is entered on the edge that begins the SLOT_START phase, so the
  // decision is made in the phase just before it (wraps for SLOT_START = 0).
  localparam logic [4:0] SS_PRE = 5'(SLOT_START - 1);

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  memr_s1_q, memr_s2_q, memw_s1_q, memw_s2_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  bus_rdy_q, bus_rdy_d;
  logic [7:0]            bus_out_q, bus_out_d;
  logic [7:0]            vid_d_q, vid_d_d;
  logic                  snow_q, snow_d;
  logic                  snow_seen_q, snow_seen_d;

  logic mem_cs, strobes_idle, cpu_req, in_access;

  assign mem_cs       = ~bus_aen & ((bus_a >> WIN_LOG2) == (FB_BASE >> WIN_LOG2));
  assign strobes_idle = memr_s2_q & memw_s2_q;
  assign cpu_req      = mem_cs & ~strobes_idle;
  assign in_access    = (state_q == ACCESS);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    bus_out_d   = bus_out_q;
    vid_d_d     = vid_d_q;
    snow_d      = 1'b0;
    snow_seen_d = snow_seen_q;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          state_d = WAIT_SLOT;
          addr_d  = bus_a[ADDR_WIDTH-1:0];
          wdata_d = bus_d;
          rd_d    = ~memr_s2_q;
        end
      end
      WAIT_SLOT: begin
        if (strobes_idle)           state_d = IDLE;
        else if (clkdiv == SS_PRE)  state_d = ACCESS;
      end
      ACCESS: begin
        if (rd_q && (clkdiv == SE)) bus_out_d = ram_d;
        if (!((clkdiv >= SS) && (clkdiv < SE))) state_d = DONE;
      end
      DONE: begin
        if (strobes_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Video capture; during the CPU slot the RAM bus carries the CPU byte,
    // which either corrupts the fetch (snow) or is simply not captured.
    if (vid_req) begin
      if (!in_access) begin
        vid_d_d = ram_d;
      end else if (SNOW != 0) begin
        vid_d_d = rd_q ? ram_d : wdata_q;
        if (!snow_seen_q) begin
          snow_d      = 1'b1;
          snow_seen_d = 1'b1;
        end
      end
    end
    if (!in_access) snow_seen_d = 1'b0;

    bus_rdy_d = ~((state_d == WAIT_SLOT) || (state_d == ACCESS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      memr_s1_q   <= 1'b1;
      memr_s2_q   <= 1'b1;
      memw_s1_q   <= 1'b1;
      memw_s2_q   <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      rd_q        <= 1'b0;
      bus_rdy_q   <= 1'b1;
      bus_out_q   <= 8'h00;
      vid_d_q     <= 8'h00;
      snow_q      <= 1'b0;
      snow_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      memr_s1_q   <= bus_memr_l;
      memr_s2_q   <= memr_s1_q;
      memw_s1_q   <= bus_memw_l;
      memw_s2_q   <= memw_s1_q;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_q        <= rd_d;
      bus_rdy_q   <= bus_rdy_d;
      bus_out_q   <= bus_out_d;
      vid_d_q     <= vid_d_d;
      snow_q      <= snow_d;
      snow_seen_q <= snow_seen_d;
    end
  end

  assign bus_dir  = mem_cs & ~bus_memr_l;
  assign bus_rdy  = (USE_BUS_WAIT != 0) ? bus_rdy_q : 1'b1;
  assign bus_out  = bus_out_q;
  assign vid_d    = vid_d_q;
  assign snow     = snow_q;
  assign ram_a    = in_access ? 19'(addr_q) : 19'(vid_a);
  assign ram_we_l = ~(in_access & ~rd_q);
  assign ram_wd   = wdata_q;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// tb/tb_cga_vram_arbiter.sv - directed self-checking bench for cga_vram_arbiter
module tb_cga_vram_arbiter;

  logic        clk;
  logic        reset;
  logic [4:0]  clkdiv;
  logic [19:0] bus_a;
  logic [7:0]  bus_d;
  logic        memr_l, memw_l, aen;
  logic [13:0] vid_a;
  logic        vid_req;
  logic [7:0]  ram_d;

  logic [7:0]  bus_out, vid_d, ram_wd;
  logic        bus_dir, bus_rdy, snow, ram_we_l;
  logic [18:0] ram_a;

  logic [7:0]  bus_out2, vid_d2, ram_wd2;
  logic        bus_dir2, bus_rdy2, snow2, ram_we_l2;
  logic [18:0] ram_a2;

  int checks = 0;
  int errors = 0;

  int we_cnt, we_first, we_last, bad, rdy_low, snow_cnt, snow2_cnt;
  logic        rdy16, rdy20, rdy21;
  logic [18:0] ra16, ra18;
  logic [7:0]  vd20, vd2_19;

  cga_vram_arbiter dut (
    .clk(clk), .reset(reset), .clkdiv(clkdiv), .bus_a(bus_a), .bus_d(bus_d),
    .bus_memr_l(memr_l), .bus_memw_l(memw_l), .bus_aen(aen),
    .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy),
    .vid_a(vid_a), .vid_req(vid_req), .vid_d(vid_d), .snow(snow),
    .ram_a(ram_a), .ram_we_l(ram_we_l), .ram_wd(ram_wd), .ram_d(ram_d)
  );

  cga_vram_arbiter #(.SNOW(1)) dut_snow (
    .clk(clk), .reset(reset), .clkdiv(clkdiv), .bus_a(bus_a), .bus_d(bus_d),
    .bus_memr_l(memr_l), .bus_memw_l(memw_l), .bus_aen(aen),
    .bus_out(bus_out2), .bus_dir(bus_dir2), .bus_rdy(bus_rdy2),
    .vid_a(vid_a), .vid_req(vid_req), .vid_d(vid_d2), .snow(snow2),
    .ram_a(ram_a2), .ram_we_l(ram_we_l2), .ram_wd(ram_wd2), .ram_d(ram_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sequencer phase: clkdiv advances just after the edge, checks happen later.
  task automatic tick();
    @(posedge clk);
    #1 clkdiv = clkdiv + 5'd1;
    #1;
  endtask

  task automatic to_phase31();
    for (int i = 0; i < 40 && clkdiv != 5'd31; i++) tick();
  endtask

  task automatic release_bus();
    memr_l = 1'b1;
    memw_l = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  // Runs phases 0..31 after a request was raised in phase 31, recording observations.
  task automatic run_frame(input int abort_cd, input bit switch_rd);
    we_cnt = 0; we_first = -1; we_last = -1; bad = 0; rdy_low = 0;
    snow_cnt = 0; snow2_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (abort_cd >= 0 && clkdiv == 5'(abort_cd)) begin
        memr_l = 1'b1; memw_l = 1'b1; #1;
      end
      if (switch_rd && clkdiv == 5'd17) begin
        ram_d = 8'h22; #1;
      end
      if (!ram_we_l) begin
        we_cnt++;
        if (we_first < 0) we_first = int'(clkdiv);
        we_last = int'(clkdiv);
        if (ram_a !== 19'h00010 || ram_wd !== bus_d) bad++;
      end
      if (!bus_rdy) rdy_low++;
      if (snow)  snow_cnt++;
      if (snow2) snow2_cnt++;
      case (clkdiv)
        5'd16: begin rdy16 = bus_rdy; ra16 = ram_a; end
        5'd18: ra18 = ram_a;
        5'd19: vd2_19 = vid_d2;
        5'd20: begin rdy20 = bus_rdy; vd20 = vid_d; end
        5'd21: rdy21 = bus_rdy;
        default: ;
      endcase
    end
  endtask

  initial begin
    reset = 1'b1; clkdiv = 5'd0; bus_a = 20'h00000; bus_d = 8'h00;
    memr_l = 1'b1; memw_l = 1'b1; aen = 1'b0; vid_a = 14'h0000;
    vid_req = 1'b0; ram_d = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    check("reset_bus_rdy", 32'(bus_rdy), 32'h1);
    check("reset_ram_we_l", 32'(ram_we_l), 32'h1);
    check("reset_snow", 32'(snow2), 32'h0);
    check("reset_bus_out", 32'(bus_out), 32'h00);
    check("reset_vid_d", 32'(vid_d), 32'h00);
    reset = 1'b0;
    tick();

    // CPU write 5A to B8010
    to_phase31();
    bus_a = 20'hB8010; bus_d = 8'h5A; memw_l = 1'b0;
    run_frame(-1, 1'b0);
    check("wr_we_cycles", 32'(we_cnt), 32'd4);
    check("wr_we_first_phase", 32'(we_first), 32'd17);
    check("wr_we_last_phase", 32'(we_last), 32'd20);
    check("wr_addr_data_bad", 32'(bad), 32'd0);
    check("wr_rdy_phase16", 32'(rdy16), 32'h0);
    check("wr_rdy_phase20", 32'(rdy20), 32'h0);
    check("wr_rdy_phase21", 32'(rdy21), 32'h1);
    release_bus();

    // CPU read of mirror BC010
    to_phase31();
    bus_a = 20'hBC010; ram_d = 8'hC3; vid_a = 14'h3FFF; memr_l = 1'b0;
    #1;
    check("rd_bus_dir", 32'(bus_dir), 32'h1);
    run_frame(-1, 1'b0);
    check("rd_no_we", 32'(we_cnt), 32'd0);
    check("rd_ram_a_slot", 32'(ra18), 32'h00010);
    check("rd_ram_a_video", 32'(ra16), 32'h03FFF);
    check("rd_bus_out", 32'(bus_out), 32'hC3);
    check("rd_rdy_phase20", 32'(rdy20), 32'h0);
    check("rd_rdy_phase21", 32'(rdy21), 32'h1);
    release_bus();
    check("rd_bus_dir_released", 32'(bus_dir), 32'h0);

    // Video capture outside the slot
    vid_req = 1'b1; ram_d = 8'h77;
    tick();
    check("vid_capture", 32'(vid_d), 32'h77);
    vid_req = 1'b0;

    // Address outside decode window
    to_phase31();
    bus_a = 20'hB0000; bus_d = 8'h01; vid_a = 14'h1234; memw_l = 1'b0;
    run_frame(-1, 1'b0);
    check("miss_no_we", 32'(we_cnt), 32'd0);
    check("miss_rdy_high", 32'(rdy_low), 32'd0);
    check("miss_ram_a", 32'(ram_a), 32'h01234);
    release_bus();

    // AEN blocks decode
    to_phase31();
    bus_a = 20'hB8010; aen = 1'b1; memw_l = 1'b0;
    run_frame(-1, 1'b0);
    check("aen_no_we", 32'(we_cnt), 32'd0);
    check("aen_rdy_high", 32'(rdy_low), 32'd0);
    memw_l = 1'b1; memr_l = 1'b0; #1;
    check("aen_bus_dir", 32'(bus_dir), 32'h0);
    release_bus();
    aen = 1'b0;

    // Snow: write FF while video fetches every cycle
    vid_req = 1'b1; ram_d = 8'h11;
    to_phase31();
    bus_a = 20'hB8010; bus_d = 8'hFF; memw_l = 1'b0;
    run_frame(-1, 1'b1);
    check("snow_pulses", 32'(snow2_cnt), 32'd1);
    check("snow_vid_d", 32'(vd2_19), 32'hFF);
    check("nosnow_pulses", 32'(snow_cnt), 32'd0);
    check("nosnow_vid_hold", 32'(vd20), 32'h11);
    release_bus();
    vid_req = 1'b0;

    // Strobe released before the slot
    to_phase31();
    bus_a = 20'hB8010; bus_d = 8'h3C; memw_l = 1'b0;
    run_frame(10, 1'b0);
    check("abort_no_we", 32'(we_cnt), 32'd0);
    check("abort_rdy_phase16", 32'(rdy16), 32'h1);
    release_bus();

    // Reset mid-write
    to_phase31();
    bus_a = 20'hB8010; bus_d = 8'hA5; memw_l = 1'b0;
    for (int i = 0; i < 40 && clkdiv != 5'd18; i++) tick();
    check("rst_pre_we_low", 32'(ram_we_l), 32'h0);
    reset = 1'b1;
    #1;
    check("rst_we_high", 32'(ram_we_l), 32'h1);
    check("rst_rdy_high", 32'(bus_rdy), 32'h1);
    memw_l = 1'b1;
    tick(); tick();
    reset = 1'b0;
    we_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!ram_we_l) we_cnt++;
    end
    check("rst_post_no_we", 32'(we_cnt), 32'd0);
    check("rst_post_rdy", 32'(bus_rdy), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
